// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the MEM-stage load/store unit.
package lsu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // {lsh,lsb} = 11 is treated as a word, matching the extender.
    function automatic logic [1:0] size_code(input logic lsh, input logic lsb);
        case ({lsh, lsb})
            2'b10:   size_code = SZ_HALF;
            2'b01:   size_code = SZ_BYTE;
            default: size_code = SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_HALF: misaligned = offset[0];
            SZ_BYTE: misaligned = 1'b0;
            default: misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Combinational store lane placement: byte enables and lane-replicated write data.
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    always_comb begin
        be    = BE_WORD;
        wdata = data;
        case (size)
            SZ_HALF: begin
                be    = offset[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata = {2{data[15:0]}};
            end
            SZ_BYTE: begin
                be    = 4'b0001 << offset;
                wdata = {4{data[7:0]}};
            end
            default: begin
                be    = BE_WORD;
                wdata = data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: alignment check, req/ack memory handshake,
// pipeline stall and raw load return to the downstream extender.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_lsh,
    input  logic        req_lsb,
    input  logic        req_lu,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_word,
    output logic [1:0]  ld_offset,
    output logic        ld_lsh,
    output logic        ld_lsb,
    output logic        ld_lu,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic [31:0] bad_addr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      op_addr;
    logic             op_lsh, op_lsb, op_lu;
    logic [1:0]       size;
    logic             mis;
    logic             timeout;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;

    assign size    = size_code(req_lsh, req_lsb);
    assign mis     = misaligned(size, req_addr[1:0]);
    assign timeout = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

    assign mem_req = (state == ST_BUSY);
    assign stall   = (state == ST_BUSY) || ((state == ST_IDLE) && req_valid && !mis);

    lsu_store_align u_align (
        .size   (size),
        .offset (req_addr[1:0]),
        .data   (req_wdata),
        .be     (st_be),
        .wdata  (st_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_addr   <= '0;
            op_lsh    <= 1'b0;
            op_lsb    <= 1'b0;
            op_lu     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            ld_valid  <= 1'b0;
            ld_word   <= '0;
            ld_offset <= '0;
            ld_lsh    <= 1'b0;
            ld_lsb    <= 1'b0;
            ld_lu     <= 1'b0;
            adel      <= 1'b0;
            ades      <= 1'b0;
            bus_err   <= 1'b0;
            bad_addr  <= '0;
        end else begin
            ld_valid <= 1'b0;
            adel     <= 1'b0;
            ades     <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        if (mis) begin
                            adel     <= !req_we;
                            ades     <= req_we;
                            bad_addr <= req_addr;
                        end else begin
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= req_we ? st_be : BE_WORD;
                            mem_wdata <= req_we ? st_wdata : '0;
                            op_addr   <= req_addr;
                            op_lsh    <= req_lsh;
                            op_lsb    <= req_lsb;
                            op_lu     <= req_lu;
                            state     <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    // An ack arriving in the timeout cycle wins over the timeout.
                    if (mem_ack) begin
                        if (!mem_we) begin
                            ld_valid  <= 1'b1;
                            ld_word   <= mem_rdata;
                            ld_offset <= op_addr[1:0];
                            ld_lsh    <= op_lsh;
                            ld_lsb    <= op_lsb;
                            ld_lu     <= op_lu;
                        end
                        state <= ST_RESP;
                    end else if (timeout) begin
                        bus_err  <= 1'b1;
                        bad_addr <= op_addr;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYC = 4).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_lsh, req_lsb, req_lu;
    logic [31:0] req_addr, req_wdata;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        ld_valid, ld_lsh, ld_lsb, ld_lu;
    logic [31:0] ld_word, bad_addr;
    logic [1:0]  ld_offset;
    logic        adel, ades, bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_lsh(req_lsh), .req_lsb(req_lsb), .req_lu(req_lu),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_word(ld_word), .ld_offset(ld_offset),
        .ld_lsh(ld_lsh), .ld_lsb(ld_lsb), .ld_lu(ld_lu),
        .adel(adel), .ades(ades), .bus_err(bus_err), .bad_addr(bad_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] d,
                         input logic lsh, input logic lsb, input logic lu);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = d;
        req_lsh = lsh; req_lsb = lsb; req_lu = lu;
        #1;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_lsh = 1'b0; req_lsb = 1'b0; req_lu = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        idle_req();
        #22;
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_bad_addr", bad_addr, 0);
        chk("rst_ld_valid", ld_valid, 0);
        rst_n = 1'b1;
        cyc();

        // sw 0x100, ack in third BUSY cycle: stall 4 cycles
        drive(1, 32'h100, 32'hDEADBEEF, 0, 0, 0);
        chk("sw_stall_n", stall, 1);
        chk("sw_req_n", mem_req, 0);
        cyc(); idle_req();
        chk("sw_req", mem_req, 1);
        chk("sw_we", mem_we, 1);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_be", mem_be, 4'b1111);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_stall1", stall, 1);
        cyc();
        chk("sw_stall2", stall, 1);
        cyc();
        chk("sw_stall3", stall, 1);
        chk("sw_req3", mem_req, 1);
        mem_ack = 1'b1;
        cyc(); mem_ack = 1'b0;
        chk("sw_resp_stall", stall, 0);
        chk("sw_resp_req", mem_req, 0);
        chk("sw_resp_ldv", ld_valid, 0);
        chk("sw_resp_berr", bus_err, 0);
        cyc();

        // sb 0x203
        drive(1, 32'h203, 32'h000000A5, 0, 1, 0);
        chk("sb_stall_n", stall, 1);
        cyc(); idle_req();
        chk("sb_addr", mem_addr, 32'h200);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        mem_ack = 1'b1;
        cyc(); mem_ack = 1'b0;
        chk("sb_ades", ades, 0);
        cyc();

        // lh 0x302
        drive(0, 32'h302, 32'hFFFFFFFF, 1, 0, 0);
        cyc(); idle_req();
        chk("lh_we", mem_we, 0);
        chk("lh_be", mem_be, 4'b1111);
        chk("lh_addr", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        cyc(); mem_ack = 1'b0; mem_rdata = '0;
        chk("lh_ldv", ld_valid, 1);
        chk("lh_word", ld_word, 32'hCAFEF00D);
        chk("lh_off", ld_offset, 2);
        chk("lh_lsh", ld_lsh, 1);
        chk("lh_lsb", ld_lsb, 0);
        chk("lh_lu", ld_lu, 0);
        cyc();
        chk("lh_ldv_pulse", ld_valid, 0);

        // lw 0x106 misaligned
        drive(0, 32'h106, 32'h0, 0, 0, 0);
        chk("adel_stall", stall, 0);
        cyc(); idle_req();
        chk("adel_pulse", adel, 1);
        chk("adel_ades", ades, 0);
        chk("adel_bad", bad_addr, 32'h106);
        chk("adel_req", mem_req, 0);
        cyc();
        chk("adel_clear", adel, 0);
        chk("adel_req2", mem_req, 0);

        // sh 0x101 misaligned
        drive(1, 32'h101, 32'h1234, 1, 0, 0);
        chk("ades_stall", stall, 0);
        cyc(); idle_req();
        chk("ades_pulse", ades, 1);
        chk("ades_adel", adel, 0);
        chk("ades_bad", bad_addr, 32'h101);
        chk("ades_req", mem_req, 0);
        cyc();

        // lw 0x500, no ack: timeout after 4 BUSY cycles
        drive(0, 32'h500, 32'h0, 0, 0, 0);
        cyc(); idle_req();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req%0d", i), mem_req, 1);
            chk($sformatf("to_berr%0d", i), bus_err, 0);
            cyc();
        end
        chk("to_req_drop", mem_req, 0);
        chk("to_berr", bus_err, 1);
        chk("to_bad", bad_addr, 32'h500);
        chk("to_ldv", ld_valid, 0);
        chk("to_stall", stall, 0);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        cyc(); mem_ack = 1'b0; mem_rdata = '0;
        chk("late_ack_ldv", ld_valid, 0);
        chk("late_ack_req", mem_req, 0);
        chk("to_berr_clear", bus_err, 0);
        cyc();

        // lbu 0x401
        drive(0, 32'h401, 32'h0, 0, 1, 1);
        cyc(); idle_req();
        mem_ack = 1'b1; mem_rdata = 32'h11223344;
        cyc(); mem_ack = 1'b0; mem_rdata = '0;
        chk("lbu_ldv", ld_valid, 1);
        chk("lbu_word", ld_word, 32'h11223344);
        chk("lbu_off", ld_offset, 1);
        chk("lbu_lu", ld_lu, 1);
        chk("lbu_lsb", ld_lsb, 1);
        cyc();
        chk("lbu_ldv_pulse", ld_valid, 0);

        // lw 0x600, ack in the timeout cycle counts as success
        drive(0, 32'h600, 32'h0, 0, 0, 0);
        cyc(); idle_req();
        cyc(); cyc(); cyc();
        chk("sim_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        cyc(); mem_ack = 1'b0; mem_rdata = '0;
        chk("sim_ldv", ld_valid, 1);
        chk("sim_berr", bus_err, 0);
        chk("sim_word", ld_word, 32'h0BADF00D);
        chk("sim_bad_kept", bad_addr, 32'h500);
        // request presented during RESP is ignored
        drive(0, 32'h602, 32'h0, 0, 0, 0);
        chk("resp_stall", stall, 0);
        cyc(); idle_req();
        chk("resp_ign_adel", adel, 0);
        chk("resp_ign_req", mem_req, 0);
        cyc();

        // reset while BUSY
        drive(1, 32'h702, 32'h9999, 1, 0, 0);
        cyc(); idle_req();
        chk("rb_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rb_req_drop", mem_req, 0);
        chk("rb_stall_drop", stall, 0);
        cyc();
        chk("rb_ades", ades, 0);
        chk("rb_berr", bus_err, 0);
        rst_n = 1'b1;
        cyc();

        // sh 0x802 after reset completes normally
        drive(1, 32'h802, 32'h0000BEEF, 1, 0, 0);
        chk("pr_stall_n", stall, 1);
        cyc(); idle_req();
        chk("pr_req", mem_req, 1);
        chk("pr_addr", mem_addr, 32'h800);
        chk("pr_be", mem_be, 4'b1100);
        chk("pr_wdata", mem_wdata, 32'hBEEFBEEF);
        mem_ack = 1'b1;
        cyc(); mem_ack = 1'b0;
        chk("pr_resp_req", mem_req, 0);
        chk("pr_resp_stall", stall, 0);
        chk("pr_berr", bus_err, 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
